// File: rtl/video_cfg_pkg.sv
// Shared types and constants for the video configuration controller.
package video_cfg_pkg;

  // Parser states
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CMD       = 3'd1,
    ST_VCFG      = 3'd2,
    ST_VCFG_DONE = 3'd3,
    ST_FWD       = 3'd4
  } state_t;

  // Settings carried by a video-config payload byte
  typedef struct packed {
    logic [1:0] scanlines;
    logic [1:0] volume;
    logic       wide;
  } cfg_t;

  // Payload byte field positions; bits [7:5] carry nothing
  localparam int SCAN_LSB = 0;
  localparam int SCAN_MSB = 1;
  localparam int VOL_LSB  = 2;
  localparam int VOL_MSB  = 3;
  localparam int WIDE_BIT = 4;

  localparam logic [7:0] VCFG_CMD_DEF = 8'h50;

  // One volume step toward the target, or hold when already there
  function automatic logic [1:0] step_toward(input logic [1:0] cur, input logic [1:0] tgt);
    if (cur < tgt) begin
      return cur + 2'd1;
    end else if (cur > tgt) begin
      return cur - 2'd1;
    end else begin
      return cur;
    end
  endfunction

endpackage

// File: rtl/video_cfg_ctrl_vol_ramp.sv
// Volume target register with a one-step-per-frame ramp toward it.
module video_cfg_ctrl_vol_ramp
  import video_cfg_pkg::*;
#(
  parameter logic [1:0] DEF_VOLUME = 2'd3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_i,
  input  logic       load_i,
  input  logic [1:0] load_value_i,
  output logic [1:0] volume_o
);

  logic [1:0] target_q;
  logic [1:0] vol_q;
  logic [1:0] tgt_eff;

  // A target loaded at this frame already drives this frame's step,
  // so a full 0->3 ramp completes in three frames.
  assign tgt_eff = load_i ? load_value_i : target_q;

  // Target load and single-step ramp, both only on frame boundaries
  always_ff @(posedge clk) begin
    if (reset) begin
      target_q <= DEF_VOLUME;
      vol_q    <= DEF_VOLUME;
    end else if (frame_i) begin
      vol_q <= step_toward(vol_q, tgt_eff);
      if (load_i) begin
        target_q <= load_value_i;
      end
    end
  end

  assign volume_o = vol_q;

endmodule

// File: rtl/video_cfg_ctrl.sv
// MCU message parser: forwards OSD traffic, captures video-config
// payloads into a shadow and applies them at vsync falling edges.
//
// state        | meaning
// ST_IDLE      | waiting for mcu_start, strobes ignored
// ST_CMD       | next strobe carries the command byte
// ST_VCFG      | next strobe carries the video-config payload
// ST_VCFG_DONE | payload taken, strobes ignored until next start
// ST_FWD       | OSD message, every strobe forwarded
module video_cfg_ctrl
  import video_cfg_pkg::*;
#(
  parameter logic [7:0] VCFG_CMD      = VCFG_CMD_DEF,
  parameter logic [1:0] DEF_SCANLINES = 2'd0,
  parameter logic [1:0] DEF_VOLUME    = 2'd3,
  parameter logic       DEF_WIDE      = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mcu_start,
  input  logic       mcu_strobe,
  input  logic [7:0] mcu_data,
  input  logic       vs_n,
  output logic       osd_start,
  output logic       osd_strobe,
  output logic [7:0] osd_data,
  output logic [1:0] system_scanlines,
  output logic [1:0] system_volume,
  output logic       system_wide_screen,
  output logic       cfg_pending,
  output logic       resync
);

  state_t     state_q;
  logic       osd_start_q;
  logic       osd_strobe_q;
  logic [7:0] osd_data_q;
  logic       fwd_pend_q;
  logic [7:0] fwd_byte_q;
  cfg_t       shadow_q;
  logic       cfg_pending_q;

  logic       vs_n_q;
  logic [1:0] scanlines_q;
  logic       wide_q;
  logic       resync_q;

  logic       boundary;
  logic       apply;
  logic       cmd_hit;

  assign boundary = vs_n_q & ~vs_n;
  assign apply    = boundary & cfg_pending_q;
  // A start in the same cycle as a strobe makes that byte the command byte
  assign cmd_hit  = mcu_strobe & (mcu_start | (state_q == ST_CMD));

  // Parser FSM with registered OSD outputs and config shadow
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      osd_start_q   <= 1'b0;
      osd_strobe_q  <= 1'b0;
      osd_data_q    <= 8'h00;
      fwd_pend_q    <= 1'b0;
      fwd_byte_q    <= 8'h00;
      shadow_q      <= '{scanlines: DEF_SCANLINES, volume: DEF_VOLUME, wide: DEF_WIDE};
      cfg_pending_q <= 1'b0;
    end else begin
      osd_start_q  <= 1'b0;
      osd_strobe_q <= 1'b0;

      // Command byte goes out one cycle behind its osd_start
      if (fwd_pend_q) begin
        osd_strobe_q <= 1'b1;
        osd_data_q   <= fwd_byte_q;
        fwd_pend_q   <= 1'b0;
      end

      // The boundary consumes the shadow; a same-cycle write below re-arms it
      if (apply) begin
        cfg_pending_q <= 1'b0;
      end

      if (cmd_hit) begin
        if (mcu_data == VCFG_CMD) begin
          state_q <= ST_VCFG;
        end else begin
          state_q     <= ST_FWD;
          osd_start_q <= 1'b1;
          fwd_pend_q  <= 1'b1;
          fwd_byte_q  <= mcu_data;
        end
      end else if (mcu_start) begin
        state_q <= ST_CMD;
      end else if (mcu_strobe) begin
        case (state_q)
          ST_VCFG: begin
            shadow_q.scanlines <= mcu_data[SCAN_MSB:SCAN_LSB];
            shadow_q.volume    <= mcu_data[VOL_MSB:VOL_LSB];
            shadow_q.wide      <= mcu_data[WIDE_BIT];
            cfg_pending_q      <= 1'b1;
            state_q            <= ST_VCFG_DONE;
          end
          ST_FWD: begin
            osd_strobe_q <= 1'b1;
            osd_data_q   <= mcu_data;
          end
          default: ;
        endcase
      end
    end
  end

  // Frame-boundary detect and application of scanlines / wide screen
  always_ff @(posedge clk) begin
    if (reset) begin
      vs_n_q      <= 1'b0;
      scanlines_q <= DEF_SCANLINES;
      wide_q      <= DEF_WIDE;
      resync_q    <= 1'b0;
    end else begin
      vs_n_q   <= vs_n;
      resync_q <= 1'b0;
      if (apply) begin
        scanlines_q <= shadow_q.scanlines;
        wide_q      <= shadow_q.wide;
        resync_q    <= (shadow_q.wide != wide_q);
      end
    end
  end

  video_cfg_ctrl_vol_ramp #(
    .DEF_VOLUME (DEF_VOLUME)
  ) u_vol_ramp (
    .clk          (clk),
    .reset        (reset),
    .frame_i      (boundary),
    .load_i       (apply),
    .load_value_i (shadow_q.volume),
    .volume_o     (system_volume)
  );

  assign osd_start          = osd_start_q;
  assign osd_strobe         = osd_strobe_q;
  assign osd_data           = osd_data_q;
  assign system_scanlines   = scanlines_q;
  assign system_wide_screen = wide_q;
  assign cfg_pending        = cfg_pending_q;
  assign resync             = resync_q;

endmodule
